// File: rtl/scope_display_ctrl.sv
// scope_display_ctrl: clear -> arm -> capture -> draw -> hold frame sequencer. Draw pixels appear 1 cycle after address issue; there is no backpressure and pix_we is a plain strobe.
// Define SCOPE_TRIGGER_EN for a channel-0 rising-edge trigger with auto-trigger timeout. Without it, ARM lasts one cycle and trig_level is ignored.
module scope_display_ctrl #(
   parameter int          H_PIXELS    = 160,
   parameter int          V_PIXELS    = 120,
   parameter int          X_W         = 8,
   parameter int          Y_W         = 8,
   parameter int          ADC_W       = 14,
   parameter int          CHANNELS    = 2,
   parameter int          HOLD_CYCLES = 10000,
   parameter int          ARM_TIMEOUT = 65535,
   parameter logic [47:0] CH_COLOR    = {12'h0F0, 12'hF0F, 12'hFF0, 12'h0FF}
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      single_shot,
   input  logic [CHANNELS*ADC_W-1:0] adc_data,
   input  logic                      adc_valid,
   input  logic [ADC_W-1:0]          trig_level,
   output logic [X_W-1:0]            pix_x,
   output logic [Y_W-1:0]            pix_y,
   output logic [11:0]               pix_color,
   output logic                      pix_we,
   output logic                      busy,
   output logic                      frame_done,
   output logic [2:0]                state_o
);

   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int ARM_W  = $clog2(ARM_TIMEOUT + 1);
   localparam logic [X_W-1:0]    X_LAST    = X_W'(H_PIXELS - 1);
   localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_PIXELS - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      ARM     = 3'd2,
      CAPTURE = 3'd3,
      DRAW    = 3'd4,
      HOLD    = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic [X_W-1:0]            clr_x;
   logic [Y_W-1:0]            clr_y;
   logic [X_W-1:0]            cap_idx;
   logic [X_W-1:0]            cap_addr;
   logic                      cap_we;
   logic [X_W-1:0]            dx;
   logic [CH_W-1:0]           dch;
   logic                      draw_done;
   logic [HOLD_W-1:0]         hold_cnt;
   logic                      rd_vld;
   logic [X_W-1:0]            rd_x;
   logic [CH_W-1:0]           rd_ch;
   logic [CHANNELS*Y_W-1:0]   rd_word;
   logic [CHANNELS*Y_W-1:0]   scaled;
   logic [CHANNELS*Y_W-1:0]   trace_mem [H_PIXELS];
   logic                      trig_hit;
   logic                      arm_done;
   logic                      unused_inputs;

   assign unused_inputs = ^adc_data;

   // Keep the top Y_W bits of the sample and clip to the last visible row.
   function automatic logic [Y_W-1:0] scale_y(input logic [ADC_W-1:0] s);
      logic [Y_W-1:0] y_raw;
      y_raw = s[ADC_W-1 -: Y_W];
      return (y_raw > Y_LAST) ? Y_LAST : y_raw;
   endfunction

   always_comb begin
      scaled = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         scaled[c*Y_W +: Y_W] = scale_y(adc_data[c*ADC_W +: ADC_W]);
      end
   end

`ifdef SCOPE_TRIGGER_EN
   logic [ADC_W-1:0] prev_s;
   logic             prev_ok;
   logic [ARM_W-1:0] arm_cnt;
   logic [ADC_W-1:0] ch0;

   assign ch0      = adc_data[ADC_W-1:0];
   assign trig_hit = (state == ARM) && adc_valid && prev_ok &&
                     (prev_s < trig_level) && (ch0 >= trig_level);
   assign arm_done = trig_hit || ((state == ARM) && (arm_cnt == ARM_W'(ARM_TIMEOUT - 1)));

   // The first valid sample in ARM only seeds prev_s, so it can never count as a crossing.
   always_ff @(posedge clk) begin
      if (!rst_n || state != ARM) begin
         prev_s  <= '0;
         prev_ok <= 1'b0;
         arm_cnt <= '0;
      end else begin
         arm_cnt <= arm_cnt + 1'b1;
         if (adc_valid) begin
            prev_s  <= ch0;
            prev_ok <= 1'b1;
         end
      end
   end
`else
   logic             unused_trig;
   logic [ARM_W-1:0] unused_arm;

   assign unused_trig = ^trig_level;
   assign unused_arm  = ARM_W'(ARM_TIMEOUT);
   assign trig_hit    = 1'b0;
   assign arm_done    = (state == ARM);
`endif

   assign cap_we   = adc_valid && ((state == CAPTURE) || trig_hit);
   assign cap_addr = (state == CAPTURE) ? cap_idx : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CLEAR;
         CLEAR:   if (clr_x == X_LAST && clr_y == Y_LAST) state_nxt = ARM;
         ARM:     if (arm_done) state_nxt = CAPTURE;
         CAPTURE: if (adc_valid && cap_idx == X_LAST) state_nxt = DRAW;
         DRAW:    if (draw_done && rd_vld) state_nxt = HOLD;
         HOLD:    if (hold_cnt == HOLD_LAST) state_nxt = (start && !single_shot) ? CLEAR : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_x     <= '0;
         clr_y     <= '0;
         cap_idx   <= '0;
         dx        <= '0;
         dch       <= '0;
         draw_done <= 1'b0;
         hold_cnt  <= '0;
         rd_vld    <= 1'b0;
         rd_x      <= '0;
         rd_ch     <= '0;
      end else begin
         rd_vld <= 1'b0;

         if (state == CLEAR) begin
            if (clr_x == X_LAST) begin
               clr_x <= '0;
               clr_y <= (clr_y == Y_LAST) ? '0 : clr_y + 1'b1;
            end else begin
               clr_x <= clr_x + 1'b1;
            end
         end else begin
            clr_x <= '0;
            clr_y <= '0;
         end

         // A trigger crossing already occupies slot 0, so capture resumes at 1.
         if (state == ARM)                       cap_idx <= trig_hit ? X_W'(1) : '0;
         else if (state == CAPTURE && adc_valid) cap_idx <= cap_idx + 1'b1;

         if (state == DRAW) begin
            if (!draw_done) begin
               rd_vld <= 1'b1;
               rd_x   <= dx;
               rd_ch  <= dch;
               if (dch == CH_LAST) begin
                  dch <= '0;
                  if (dx == X_LAST) draw_done <= 1'b1;
                  else              dx <= dx + 1'b1;
               end else begin
                  dch <= dch + 1'b1;
               end
            end
         end else begin
            dx        <= '0;
            dch       <= '0;
            draw_done <= 1'b0;
         end

         hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      end
   end

   // Trace buffer holds every channel of one sample per word; contents are never reset.
   always_ff @(posedge clk) begin
      if (cap_we) trace_mem[cap_addr] <= scaled;
      if (state == DRAW && !draw_done) rd_word <= trace_mem[dx];
   end

   always_comb begin
      pix_we    = 1'b0;
      pix_x     = '0;
      pix_y     = '0;
      pix_color = '0;
      if (state == CLEAR) begin
         pix_we = 1'b1;
         pix_x  = clr_x;
         pix_y  = clr_y;
      end else if (rd_vld) begin
         pix_we    = 1'b1;
         pix_x     = rd_x;
         pix_y     = rd_word[rd_ch*Y_W +: Y_W];
         pix_color = CH_COLOR[rd_ch*12 +: 12];
      end
   end

   assign busy       = (state != IDLE);
   assign frame_done = (state == HOLD) && (hold_cnt == HOLD_LAST);
   assign state_o    = state;

endmodule

// File: tb/tb_scope_display_ctrl.sv
// Directed bench for scope_display_ctrl: reset vector table, mid-clear reset, free-run and single-shot frames.
module tb_scope_display_ctrl;

   localparam int H    = 160;
   localparam int V    = 120;
   localparam int AW   = 14;
   localparam int CH   = 2;
   localparam int HOLD = 16;
   localparam int ATO  = 100;
`ifdef SCOPE_TRIGGER_EN
   localparam int ARM_EXP = ATO;
`else
   localparam int ARM_EXP = 1;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             single_shot;
   logic [CH*AW-1:0] adc_data;
   logic             adc_valid;
   logic [AW-1:0]    trig_level;
   logic [7:0]       pix_x;
   logic [7:0]       pix_y;
   logic [11:0]      pix_color;
   logic             pix_we;
   logic             busy;
   logic             frame_done;
   logic [2:0]       state_o;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   scope_display_ctrl #(
      .H_PIXELS(H), .V_PIXELS(V), .X_W(8), .Y_W(8), .ADC_W(AW), .CHANNELS(CH),
      .HOLD_CYCLES(HOLD), .ARM_TIMEOUT(ATO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .single_shot(single_shot),
      .adc_data(adc_data), .adc_valid(adc_valid), .trig_level(trig_level),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_we(pix_we),
      .busy(busy), .frame_done(frame_done), .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int clr_n, clr_bad, arm_n, cap_n, draw_n, draw_bad, idle_bad, hold_n, fd_n, fd_bad, end_bad;
      logic [2:0] end_state;
      bit         timeout;
   } fstat_t;

   // Entered at a negedge showing CLEAR write 0; returns at the first sample after HOLD.
   task automatic run_frame(input int every, output fstat_t s);
      int cx, cy;
      logic [2:0] prev_st;
      logic prev_we;
      logic [7:0] ex, ey;
      logic [11:0] ec;
      s = '{default: 0};
      cx = 0; cy = 0; prev_st = 3'd1; prev_we = 1'b0;
      for (int cyc = 0; cyc < 30000; cyc++) begin
         if (prev_st == 3'd5 && state_o != 3'd5) begin
            s.end_state = state_o;
            return;
         end
         case (state_o)
            3'd1: begin
               if (pix_we !== 1'b1 || pix_x != 8'(cx) || pix_y != 8'(cy) || pix_color != 12'h000)
                  s.clr_bad++;
               s.clr_n++;
               cx++;
               if (cx == H) begin cx = 0; cy++; end
            end
            3'd2: s.arm_n++;
            3'd3: s.cap_n++;
            3'd4: if (pix_we) begin
               ex = 8'(s.draw_n / 2);
               ey = (s.draw_n % 2 == 1) ? 8'd119 : 8'd64;
               ec = (s.draw_n % 2 == 1) ? 12'hFF0 : 12'h0FF;
               if (pix_x != ex || pix_y != ey || pix_color != ec) s.draw_bad++;
               s.draw_n++;
            end
            3'd5: begin
               if (s.hold_n == 0 && !(prev_st == 3'd4 && prev_we)) s.end_bad++;
               s.hold_n++;
            end
            default: s.end_bad++;
         endcase
         if (!pix_we && (pix_x != 0 || pix_y != 0 || pix_color != 0)) s.idle_bad++;
         if (state_o != 3'd1 && state_o != 3'd4 && pix_we) s.idle_bad++;
         if (frame_done) begin
            s.fd_n++;
            if (state_o != 3'd5 || s.hold_n != HOLD) s.fd_bad++;
         end
         prev_st = state_o;
         prev_we = pix_we;
         adc_valid = ((cyc + 1) % every == 0);
         @(negedge clk);
      end
      s.timeout = 1'b1;
   endtask

   task automatic check_frame(input string tag, input fstat_t s, input logic [2:0] end_exp);
      check({tag, "_timeout"}, s.timeout, 0);
      check({tag, "_clear_writes"}, s.clr_n, H * V);
      check({tag, "_clear_order_black"}, s.clr_bad, 0);
      check({tag, "_arm_cycles"}, s.arm_n, ARM_EXP);
      check({tag, "_draw_writes"}, s.draw_n, H * CH);
      check({tag, "_draw_pixels"}, s.draw_bad, 0);
      check({tag, "_zero_when_idle"}, s.idle_bad, 0);
      check({tag, "_hold_cycles"}, s.hold_n, HOLD);
      check({tag, "_frame_done_pulses"}, s.fd_n, 1);
      check({tag, "_frame_done_timing"}, s.fd_bad, 0);
      check({tag, "_hold_after_last_draw"}, s.end_bad, 0);
      check({tag, "_next_state"}, s.end_state, end_exp);
   endtask

   typedef struct {
      logic       rst_n;
      logic       start;
      logic [2:0] st;
      logic       busy;
      logic       we;
      logic [7:0] x;
   } rvec_t;

   initial begin
      rvec_t  rv [8];
      fstat_t fs;
      int     bad;

      rv[0] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'd0};
      rv[1] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0};
      rv[2] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 8'd0};
      rv[3] = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 8'd1};
      rv[4] = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 8'd2};
      rv[5] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'd0};
      rv[6] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0};
      rv[7] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 8'd0};

      rst_n       = 1'b0;
      start       = 1'b0;
      single_shot = 1'b0;
      adc_valid   = 1'b0;
      adc_data    = {14'h3FFF, 14'h1000};
      trig_level  = 14'h1000;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         rst_n = rv[i].rst_n;
         start = rv[i].start;
         @(negedge clk);
         check($sformatf("vec%0d_state", i), state_o, rv[i].st);
         check($sformatf("vec%0d_busy", i), busy, rv[i].busy);
         check($sformatf("vec%0d_we", i), pix_we, rv[i].we);
         check($sformatf("vec%0d_x", i), pix_x, rv[i].x);
         check($sformatf("vec%0d_y", i), pix_y, 0);
         check($sformatf("vec%0d_color_done", i), {pix_color, frame_done}, 0);
      end

      // Reset while CLEAR is showing write 500 (row 3, column 20).
      repeat (500) @(negedge clk);
      check("clr500_x", pix_x, 20);
      check("clr500_y", pix_y, 3);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset_state", state_o, 0);
      check("midreset_we", pix_we, 0);
      check("midreset_busy", busy, 0);
      check("midreset_outputs", {pix_x, pix_y, pix_color, frame_done}, 0);

      // Free-running frame with a sample every cycle; ends by restarting CLEAR.
      rst_n = 1'b1;
      start = 1'b1;
      adc_valid = 1'b1;
      @(negedge clk);
      run_frame(1, fs);
      check_frame("freerun", fs, 3'd1);
      check("freerun_capture_cycles", fs.cap_n, H);

      // single_shot raised mid-frame must not abort it; samples arrive every 4th cycle.
      single_shot = 1'b1;
      run_frame(4, fs);
      check_frame("single", fs, 3'd0);
      check("single_capture_len_640pm3", (fs.cap_n >= 637 && fs.cap_n <= 643), 1);
      check("single_busy_after", busy, 0);
      start = 1'b0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (pix_we || state_o != 3'd0 || busy || frame_done) bad++;
      end
      check("single_quiet_after", bad, 0);

`ifdef SCOPE_TRIGGER_EN
      begin
         int   k, n;
         logic [7:0] ys [3];
         start = 1'b1;
         adc_valid = 1'b0;
         n = 0;
         while (state_o != 3'd2 && n < 25000) begin @(negedge clk); n++; end
         check("trig_reached_arm", state_o, 2);
         k = 0;
         n = 0;
         while (state_o != 3'd4 && n < 2000) begin
            adc_valid = 1'b1;
            adc_data[AW-1:0] = AW'(k * 256);
            k++;
            @(negedge clk);
            n++;
         end
         check("trig_reached_draw", state_o, 4);
         adc_valid = 1'b0;
         n = 0;
         for (int c = 0; c < 400 && n < 3; c++) begin
            if (pix_we && pix_color == 12'h0FF) begin
               ys[n] = pix_y;
               check($sformatf("trig_x%0d", n), pix_x, n);
               n++;
            end
            @(negedge clk);
         end
         check("trig_count", n, 3);
         check("trig_y0", ys[0], 64);
         check("trig_y1", ys[1], 68);
         check("trig_y2", ys[2], 72);
         start = 1'b0;
         n = 0;
         while (state_o != 3'd0 && n < 1000) begin @(negedge clk); n++; end
         check("trig_back_idle", state_o, 0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
